cache_refill_ctrl: RTL and testbench

Cache controller between the CPU load/store port and the direct-mapped data cache, with the main-memory port behind it. Policy is write-through with write-allocate: loads that hit complete in one cycle; loads that miss stall the CPU, fetch the word from main memory and fill the cache. Stores are written into the cache and forwarded to main memory. The controller also keeps saturating hit and miss statistics counters.

---
 rtl/cache_refill_ctrl.sv | 134 +++++++++++++
 tb/tb_cache_refill_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Write-through, write-allocate controller between a CPU port, a direct-mapped cache and memory.
// Load hits finish in the request cycle; load misses refill from memory; stores go through.
module cache_refill_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_ready_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,

  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic [DATA_WIDTH-1:0] cache_wdata_o,
  output logic                  cache_we_o,
  input  logic                  cache_hit_i,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,

  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRefill = 2'b01,
    StWback  = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic                  ready;
  logic                  cache_we;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] cache_wdata;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ready       = 1'b0;
    cache_we    = 1'b0;
    rdata       = '0;
    cache_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req_i) begin
          if (cpu_we_i) begin
            // Allocate into the cache immediately, then write through.
            cache_we    = 1'b1;
            cache_wdata = cpu_wdata_i;
            addr_d      = cpu_addr_i;
            data_d      = cpu_wdata_i;
            state_d     = StWback;
          end else if (cache_hit_i) begin
            ready = 1'b1;
            rdata = cache_rdata_i;
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
          end else begin
            addr_d  = cpu_addr_i;
            state_d = StRefill;
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      StRefill: begin
        if (mem_ack_i) begin
          cache_we    = 1'b1;
          cache_wdata = mem_rdata_i;
          ready       = 1'b1;
          rdata       = mem_rdata_i;
          state_d     = StIdle;
        end
      end
      StWback: begin
        if (mem_ack_i) begin
          ready   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Strobes are suppressed during reset so an abandoned access never writes the cache.
  assign cpu_ready_o   = ready & cpu_req_i & ~reset;
  assign cache_we_o    = cache_we & ~reset;
  assign cpu_rdata_o   = rdata;
  assign cache_wdata_o = cache_wdata;
  assign cache_addr_o  = (state_q == StIdle) ? cpu_addr_i : addr_q;

  assign mem_req_o   = (state_q == StRefill) || (state_q == StWback);
  assign mem_we_o    = (state_q == StWback);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = data_q;

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: a bench-owned direct-mapped cache, a transaction-level model of
// expected per-cycle outputs, directed scenarios with literal pins, then random traffic.
module tb_cache_refill_ctrl;

  localparam int KIDLE = 0, KRESET = 1, KHIT = 2, KMISS = 3, KSTORE = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        cpu_ready, cache_we, cache_hit, mem_req, mem_we;
  logic [31:0] cpu_rdata, cache_addr, cache_wdata, cache_rdata, mem_addr, mem_wdata;
  logic [15:0] hit_cnt, miss_cnt;

  logic        d2_ready, d2_cache_we, d2_mem_req, d2_mem_we;
  logic [31:0] d2_rdata, d2_cache_addr, d2_cache_wdata, d2_mem_addr, d2_mem_wdata;
  logic [1:0]  d2_hit_cnt, d2_miss_cnt;

  cache_refill_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ready_o(cpu_ready), .cpu_rdata_o(cpu_rdata),
    .cache_addr_o(cache_addr), .cache_wdata_o(cache_wdata), .cache_we_o(cache_we),
    .cache_hit_i(cache_hit), .cache_rdata_i(cache_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  // Narrow-counter copy driven with identical inputs, only its counters are checked.
  cache_refill_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ready_o(d2_ready), .cpu_rdata_o(d2_rdata),
    .cache_addr_o(d2_cache_addr), .cache_wdata_o(d2_cache_wdata), .cache_we_o(d2_cache_we),
    .cache_hit_i(cache_hit), .cache_rdata_i(cache_rdata),
    .mem_req_o(d2_mem_req), .mem_we_o(d2_mem_we), .mem_addr_o(d2_mem_addr),
    .mem_wdata_o(d2_mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .hit_cnt_o(d2_hit_cnt), .miss_cnt_o(d2_miss_cnt)
  );

  // Environment cache: 8 sets, index addr[4:2], tag addr[31:5].
  logic        env_valid [8];
  logic [26:0] env_tag   [8];
  logic [31:0] env_data  [8];
  logic [2:0]  env_idx;
  assign env_idx     = cache_addr[4:2];
  assign cache_hit   = env_valid[env_idx] && (env_tag[env_idx] == cache_addr[31:5]);
  assign cache_rdata = cache_hit ? env_data[env_idx] : 32'h0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) env_valid[i] <= 1'b0;
    end else if (cache_we) begin
      env_valid[env_idx] <= 1'b1;
      env_tag[env_idx]   <= cache_addr[31:5];
      env_data[env_idx]  <= cache_wdata;
    end
  end

  // Reference model state.
  logic        m_valid [8];
  logic [26:0] m_tag   [8];
  logic [31:0] m_data  [8];
  logic [31:0] mem_m [logic [31:0]];
  int          hit_m = 0, miss_m = 0, hit2_m = 0, miss2_m = 0;

  int          cur_kind = KRESET, cur_k = 0, cur_d = 0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, exp_rdata = '0;
  bit          chk_en = 1'b0;

  int          n_chk = 0, n_fail = 0;
  int          ready_cycles = 0, we_pulses = 0, mem_req_cycles = 0, last_ready_k = -1;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'hC3A5_0F96;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      if (cpu_ready) begin
        ready_cycles++;
        last_ready_k = cur_k;
        last_rdata   = cpu_rdata;
      end
      if (cache_we) we_pulses++;
      if (mem_req) mem_req_cycles++;

      chk("hit_cnt", 64'(hit_cnt), 64'(hit_m));
      chk("miss_cnt", 64'(miss_cnt), 64'(miss_m));
      chk("hit_cnt_w2", 64'(d2_hit_cnt), 64'(hit2_m));
      chk("miss_cnt_w2", 64'(d2_miss_cnt), 64'(miss2_m));

      case (cur_kind)
        KIDLE: begin
          chk("idle_ready", 64'(cpu_ready), 64'd0);
          chk("idle_cache_we", 64'(cache_we), 64'd0);
          chk("idle_mem_req", 64'(mem_req), 64'd0);
          chk("idle_mem_we", 64'(mem_we), 64'd0);
        end
        KRESET: begin
          chk("rst_ready", 64'(cpu_ready), 64'd0);
          chk("rst_cache_we", 64'(cache_we), 64'd0);
        end
        KHIT: begin
          chk("hit_ready", 64'(cpu_ready), 64'd1);
          chk("hit_rdata", 64'(cpu_rdata), 64'(exp_rdata));
          chk("hit_cache_we", 64'(cache_we), 64'd0);
          chk("hit_mem_req", 64'(mem_req), 64'd0);
          chk("hit_cache_addr", 64'(cache_addr), 64'(cur_addr));
        end
        KMISS: begin
          chk("miss_cache_addr", 64'(cache_addr), 64'(cur_addr));
          if (cur_k == 0) begin
            chk("miss_ready0", 64'(cpu_ready), 64'd0);
            chk("miss_cache_we0", 64'(cache_we), 64'd0);
            chk("miss_mem_req0", 64'(mem_req), 64'd0);
          end else begin
            chk("miss_mem_req", 64'(mem_req), 64'd1);
            chk("miss_mem_we", 64'(mem_we), 64'd0);
            chk("miss_mem_addr", 64'(mem_addr), 64'(cur_addr));
            chk("miss_ready", 64'(cpu_ready), 64'(cur_k == cur_d + 1));
            chk("miss_cache_we", 64'(cache_we), 64'(cur_k == cur_d + 1));
            if (cur_k == cur_d + 1) begin
              chk("miss_rdata", 64'(cpu_rdata), 64'(exp_rdata));
              chk("fill_wdata", 64'(cache_wdata), 64'(exp_rdata));
            end
          end
        end
        KSTORE: begin
          if (cur_k == 0) begin
            chk("st_cache_we0", 64'(cache_we), 64'd1);
            chk("st_cache_wdata", 64'(cache_wdata), 64'(cur_wdata));
            chk("st_cache_addr", 64'(cache_addr), 64'(cur_addr));
            chk("st_ready0", 64'(cpu_ready), 64'd0);
            chk("st_mem_req0", 64'(mem_req), 64'd0);
          end else begin
            chk("st_cache_we", 64'(cache_we), 64'd0);
            chk("st_mem_req", 64'(mem_req), 64'd1);
            chk("st_mem_we", 64'(mem_we), 64'd1);
            chk("st_mem_addr", 64'(mem_addr), 64'(cur_addr));
            chk("st_mem_wdata", 64'(mem_wdata), 64'(cur_wdata));
            chk("st_ready", 64'(cpu_ready), 64'(cur_k == cur_d + 1));
          end
        end
        default: ;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    hit_m = 0; miss_m = 0; hit2_m = 0; miss2_m = 0;
  endtask

  task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
    m_valid[a[4:2]] = 1'b1;
    m_tag[a[4:2]]   = a[31:5];
    m_data[a[4:2]]  = d;
  endtask

  task automatic mon_clear();
    ready_cycles = 0; we_pulses = 0; mem_req_cycles = 0; last_ready_k = -1; last_rdata = '0;
  endtask

  task automatic idle(input int n);
    cpu_req = 1'b0; mem_ack = 1'b0; cur_kind = KIDLE; cur_k = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; cpu_req = 1'b0; mem_ack = 1'b0; cur_kind = KRESET;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
    model_clear();
    cur_kind = KIDLE;
  endtask

  // One CPU access; d is the number of memory-wait cycles before mem_ack.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd, input int d);
    bit hit;
    int n;
    hit = !we && m_valid[a[4:2]] && (m_tag[a[4:2]] == a[31:5]);
    cur_kind  = we ? KSTORE : (hit ? KHIT : KMISS);
    cur_addr  = a;
    cur_wdata = wd;
    cur_d     = d;
    exp_rdata = hit ? m_data[a[4:2]] : mem_word(a);
    n = hit ? 1 : d + 2;
    for (int k = 0; k < n; k++) begin
      cur_k     = k;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      mem_ack   = (!hit && k == d + 1);
      mem_rdata = (mem_ack && !we) ? exp_rdata : $urandom;
      step();
      if (k == 0 && !we) begin
        if (hit) begin
          hit_m = sat(hit_m, 65535); hit2_m = sat(hit2_m, 3);
        end else begin
          miss_m = sat(miss_m, 65535); miss2_m = sat(miss2_m, 3);
        end
      end
      if (k == 0 && we) model_fill(a, wd);
      if (!hit && k == d + 1) begin
        if (we) mem_m[a] = wd;
        else model_fill(a, exp_rdata);
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    mem_m[32'h40] = 32'hDEAD_BEEF;
    model_clear();
    step(); step();
    reset = 1'b0;
    cur_kind = KIDLE;
    chk_en = 1'b1;
    step();
    chk("reset_ready", 64'(cpu_ready), 64'd0);
    chk("reset_cache_we", 64'(cache_we), 64'd0);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_counts", 64'({hit_cnt, miss_cnt}), 64'd0);

    // 1: miss with three wait cycles, then a hit on the same word.
    mon_clear();
    access(1'b0, 32'h40, 32'h0, 3);
    idle(1);
    chk("t1_ready_cycle", 64'(last_ready_k), 64'd4);
    chk("t1_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
    chk("t1_fill_pulses", 64'(we_pulses), 64'd1);
    chk("t1_miss_cnt", 64'(miss_cnt), 64'd1);
    chk("t1_hit_cnt0", 64'(hit_cnt), 64'd0);
    mon_clear();
    access(1'b0, 32'h40, 32'h0, 0);
    idle(1);
    chk("t1_hit_cycle", 64'(last_ready_k), 64'd0);
    chk("t1_hit_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
    chk("t1_hit_cnt", 64'(hit_cnt), 64'd1);

    // 2: store write-through, then read back from the cache.
    mon_clear();
    access(1'b1, 32'h80, 32'h1234_5678, 1);
    idle(1);
    chk("t2_mem_req_cycles", 64'(mem_req_cycles), 64'd2);
    chk("t2_we_pulses", 64'(we_pulses), 64'd1);
    chk("t2_ready_cycle", 64'(last_ready_k), 64'd2);
    mon_clear();
    access(1'b0, 32'h80, 32'h0, 0);
    idle(1);
    chk("t2_load_rdata", 64'(last_rdata), 64'h1234_5678);
    chk("t2_load_cycle", 64'(last_ready_k), 64'd0);

    // 3: conflict misses in set 0.
    do_reset(1);
    access(1'b0, 32'h00, 32'h0, 1);
    access(1'b0, 32'h20, 32'h0, 2);
    idle(1);
    chk("t3_miss_cnt2", 64'(miss_cnt), 64'd2);
    access(1'b0, 32'h00, 32'h0, 0);
    idle(1);
    chk("t3_miss_cnt3", 64'(miss_cnt), 64'd3);

    // 4: reset while refilling, with an ack in the reset cycle and a late one after.
    mon_clear();
    cur_kind = KMISS; cur_addr = 32'h1C0; cur_d = 100;
    for (int k = 0; k < 3; k++) begin
      cur_k = k; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1C0; mem_ack = 1'b0;
      step();
      if (k == 0) begin
        miss_m = sat(miss_m, 65535); miss2_m = sat(miss2_m, 3);
      end
    end
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; cur_kind = KRESET;
    step();
    reset = 1'b0;
    model_clear();
    cur_kind = KIDLE; cpu_req = 1'b0; mem_ack = 1'b1;
    step();
    chk("t4_mem_req_after", 64'(mem_req), 64'd0);
    mem_ack = 1'b0;
    step();
    chk("t4_no_fill", 64'(we_pulses), 64'd0);
    chk("t4_no_ready", 64'(ready_cycles), 64'd0);
    chk("t4_counts", 64'({hit_cnt, miss_cnt}), 64'd0);

    // 5: eight back-to-back hits.
    do_reset(1);
    for (int i = 0; i < 8; i++) access(1'b0, 32'h100 + 32'(4 * i), 32'h0, i % 3);
    idle(1);
    mon_clear();
    for (int i = 0; i < 8; i++) access(1'b0, 32'h100 + 32'(4 * i), 32'h0, 0);
    idle(1);
    chk("t5_ready_cycles", 64'(ready_cycles), 64'd8);
    chk("t5_mem_req", 64'(mem_req_cycles), 64'd0);
    chk("t5_hit_cnt", 64'(hit_cnt), 64'd8);
    chk("t5_miss_cnt", 64'(miss_cnt), 64'd8);

    // 6: narrow counter saturation; d=0 puts the ack in the first mem_req cycle.
    do_reset(1);
    for (int i = 0; i < 5; i++) access(1'b0, 32'h200 + 32'(32 * i), 32'h0, 0);
    idle(1);
    chk("t6_miss_sat", 64'(d2_miss_cnt), 64'd3);
    chk("t6_miss_wide", 64'(miss_cnt), 64'd5);

    // Random traffic over 32 words sharing 8 sets.
    for (int t = 0; t < 300; t++) begin
      access(($urandom % 3) == 0, 32'(($urandom % 32) * 4), $urandom, int'($urandom % 4));
      if (($urandom % 3) == 0) idle(int'($urandom % 2) + 1);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
